// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - two-register shift execution stage with valid/ready handshake
//
// barrel_shifter: combinational 32-bit shifter.
//   data_i  : operand
//   shamt_i : shift amount 0..31
//   lr_i    : 1 = shift left, 0 = shift right
//   al_i    : for right shifts, 1 = arithmetic (sign fill), 0 = logical
//   data_o  : shifted result
//
// shift_stage: S1 holds the captured request, S2 holds the registered result.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : synchronous kill of everything in flight
//   in_valid/in_ready : request handshake
//   in_op             : 00 SLL, 01 SRL, 11 SRA, 10 illegal
//   in_a, in_b        : operand and shift source (only in_b[4:0] matters)
//   in_tag            : destination tag carried alongside the op
//   out_valid/out_ready : result handshake
//   out_data, out_tag, out_err : result, its tag, illegal-op flag

module barrel_shifter (
    input  logic [31:0] data_i,
    input  logic [4:0]  shamt_i,
    input  logic        lr_i,
    input  logic        al_i,
    output logic [31:0] data_o
);
    logic [31:0] stage [0:5];
    logic        fill;

    // Left shifts are done by bit-reversing, shifting right, and reversing back,
    // so a single right-shifting log ladder serves all three shift kinds.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            stage[0][i] = lr_i ? data_i[31 - i] : data_i[i];
        end
    end

    assign fill = al_i & ~lr_i & data_i[31];

    genvar k;
    generate
        for (k = 0; k < 5; k++) begin : g_ladder
            localparam int SH = 1 << k;
            assign stage[k + 1] = shamt_i[k]
                ? {{SH{fill}}, stage[k][31:SH]}
                : stage[k];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            data_o[i] = lr_i ? stage[5][31 - i] : stage[5][i];
        end
    end
endmodule

module shift_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_BAD = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // S1: captured request
    logic             s1_v_q,    s1_v_d;
    logic [1:0]       s1_op_q,   s1_op_d;
    logic [31:0]      s1_a_q,    s1_a_d;
    logic [4:0]       s1_sh_q,   s1_sh_d;
    logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;

    // S2: registered result
    logic             s2_v_q,    s2_v_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q,  s2_tag_d;
    logic             s2_err_q,  s2_err_d;

    logic        in_fire;
    logic        s1_adv;
    logic        sh_lr;
    logic        sh_al;
    logic [31:0] sh_res;
    logic        unused_b_hi;

    // Only the low five bits of the shift source are meaningful.
    assign unused_b_hi = ^in_b[31:5];

    assign s1_adv   = s1_v_q && (!s2_v_q || out_ready);
    assign in_ready = !rst && (!s1_v_q || s1_adv);
    assign in_fire  = in_valid && in_ready;

    assign sh_lr = (s1_op_q == OP_SLL);
    assign sh_al = (s1_op_q == OP_SRA);

    barrel_shifter u_barrel (
        .data_i  (s1_a_q),
        .shamt_i (s1_sh_q),
        .lr_i    (sh_lr),
        .al_i    (sh_al),
        .data_o  (sh_res)
    );

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_sh_d  = s1_sh_q;
        s1_tag_d = s1_tag_q;

        if (in_fire) begin
            s1_op_d  = in_op;
            s1_a_d   = in_a;
            s1_sh_d  = in_b[4:0];
            s1_tag_d = in_tag;
        end

        if (flush) begin
            // A request accepted in the flush cycle is dropped along with the rest.
            s1_v_d = 1'b0;
        end else if (in_fire) begin
            s1_v_d = 1'b1;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;
        s2_err_d  = s2_err_q;

        // Result fields only change on a load, so they stay stable under backpressure.
        if (s1_adv) begin
            s2_tag_d = s1_tag_q;
            case (s1_op_q)
                OP_SLL, OP_SRL, OP_SRA: begin
                    s2_data_d = sh_res;
                    s2_err_d  = 1'b0;
                end
                OP_BAD: begin
                    s2_data_d = s1_a_q;
                    s2_err_d  = 1'b1;
                end
                default: begin
                    s2_data_d = s1_a_q;
                    s2_err_d  = 1'b1;
                end
            endcase
        end

        if (flush) begin
            s2_v_d = 1'b0;
        end else if (s1_adv) begin
            s2_v_d = 1'b1;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_op_q   <= 2'b00;
            s1_a_q    <= 32'd0;
            s1_sh_q   <= 5'd0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= 32'd0;
            s2_tag_q  <= '0;
            s2_err_q  <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_op_q   <= s1_op_d;
            s1_a_q    <= s1_a_d;
            s1_sh_q   <= s1_sh_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s2_tag_d;
            s2_err_q  <= s2_err_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_err   = s2_err_q;
endmodule

// File: tb/tb_shift_stage.sv
// tb/tb_shift_stage.sv - directed self-checking bench for shift_stage
module tb_shift_stage;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    int total = 0;
    int bad   = 0;

    shift_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, '0);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        total++; if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        step(); step();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_shift_ops();
        logic [1:0]       ops  [8] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01};
        logic [31:0]      as   [8] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h12345678,
                                       32'h7FFFFFF0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0]      bs   [8] = '{32'd31, 32'hFFFFFFE4, 32'hFFFFFFE4, 32'd3,
                                       32'd4, 32'hFFFFFFE0, 32'd31, 32'd31};
        logic [TAG_W-1:0] tags [8] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd9, 5'd31, 5'd0, 5'd17};
        logic [31:0]      exp  [8] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h12345678,
                                       32'h07FFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00000001};
        logic             eerr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ops[i], as[i], bs[i], tags[i]);
            step();
            drive(1'b0, 2'b00, 32'd0, 32'd0, '0);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL op%0d_early_valid: got %b want 0", i, out_valid); end
            step();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL op%0d_valid: got %b want 1", i, out_valid); end
            total++; if (out_data !== exp[i]) begin bad++; $display("FAIL op%0d_data: got %h want %h", i, out_data, exp[i]); end
            total++; if (out_err !== eerr[i]) begin bad++; $display("FAIL op%0d_err: got %b want %b", i, out_err, eerr[i]); end
            total++; if (out_tag !== tags[i]) begin bad++; $display("FAIL op%0d_tag: got %h want %h", i, out_tag, tags[i]); end
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL op%0d_drained: got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [TAG_W-1:0] et;
        logic [31:0]      ed;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, 2'b00, 32'(i + 1), 32'd1, TAG_W'(10 + i));
            else       drive(1'b0, 2'b00, 32'd0, 32'd0, '0);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, in_ready); end
            step();
            if (i >= 1 && i <= 4) begin
                et = TAG_W'(10 + i - 1);
                ed = 32'(i) << 1;
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d: got %b want 1", i, out_valid); end
                total++; if (out_tag !== et) begin bad++; $display("FAIL b2b_tag%0d: got %h want %h", i, out_tag, et); end
                total++; if (out_data !== ed) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, out_data, ed); end
            end else if (i == 5) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
            end
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h100, 32'd0, 5'd1);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_rdy1: got %b want 1", in_ready); end
        step();
        drive(1'b1, 2'b00, 32'h200, 32'd0, 5'd2);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_rdy2: got %b want 1", in_ready); end
        step();
        drive(1'b1, 2'b00, 32'h300, 32'd0, 5'd3);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_rdy3: got %b want 0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_tag !== 5'd1) begin bad++; $display("FAIL stall_head: got v=%b tag=%h want v=1 tag=01", out_valid, out_tag); end
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (out_tag !== 5'd1 || out_data !== 32'h100 || out_err !== 1'b0 || out_valid !== 1'b1)
                begin bad++; $display("FAIL stall_hold%0d: got v=%b tag=%h data=%h err=%b want 1/01/00000100/0", k, out_valid, out_tag, out_data, out_err); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold_rdy%0d: got %b want 0", k, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_rdy: got %b want 1", in_ready); end
        step();
        drive(1'b0, 2'b00, 32'd0, 32'd0, '0);
        total++; if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_data !== 32'h200) begin bad++; $display("FAIL stall_out2: got v=%b tag=%h data=%h want 1/02/00000200", out_valid, out_tag, out_data); end
        step();
        total++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_data !== 32'h300) begin bad++; $display("FAIL stall_out3: got v=%b tag=%h data=%h want 1/03/00000300", out_valid, out_tag, out_data); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h4, 32'd0, 5'd4);
        step();
        drive(1'b1, 2'b00, 32'h5, 32'd0, 5'd5);
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_prefill: got %b want 1", out_valid); end
        drive(1'b1, 2'b00, 32'h6, 32'd0, 5'd6);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, '0);
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale%0d: got v=%b tag=%h want v=0", k, out_valid, out_tag); end
            step();
        end
        drive(1'b1, 2'b00, 32'hAB, 32'd4, 5'd8);
        step();
        drive(1'b0, 2'b00, 32'd0, 32'd0, '0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_next_early: got %b want 0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_tag !== 5'd8 || out_data !== 32'hAB0) begin bad++; $display("FAIL flush_next: got v=%b tag=%h data=%h want 1/08/00000ab0", out_valid, out_tag, out_data); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 32'hF0, 32'd4, 5'd9);
        step();
        drive(1'b1, 2'b01, 32'hF00, 32'd4, 5'd10);
        step();
        drive(1'b0, 2'b00, 32'd0, 32'd0, '0);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h0F) begin bad++; $display("FAIL rstmid_prefill: got v=%b data=%h want 1/0000000f", out_valid, out_data); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_tag !== '0 || out_err !== 1'b0)
            begin bad++; $display("FAIL rstmid_outputs: got v=%b data=%h tag=%h err=%b want all 0", out_valid, out_data, out_tag, out_err); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
        step();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_ghost%0d: got %b want 0", k, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_shift_ops();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 SHALL have parameter: TAG_W, 5, width of destination-register tag carried with each op.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: flush  input  1  synchronous kill of all in-flight ops.
REQ-005 SHALL have port: in_valid  input  1  request present.
REQ-006 SHALL have port: in_ready  output  1  stage can accept request this cycle.
REQ-007 SHALL have port: in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 illegal.
REQ-008 SHALL have port: in_a  input  32  operand to shift.
REQ-009 SHALL have port: in_b  input  32  shift source; only in_b[4:0] used.
REQ-010 SHALL have port: in_tag  input  TAG_W  destination tag.
REQ-011 SHALL have port: out_valid  output  1  result present.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port: out_data  output  32  shift result.
REQ-014 SHALL have port: out_tag  output  TAG_W  tag of result.
REQ-015 SHALL have port: out_err  output  1  result came from illegal op.

Function
REQ-016 SHALL implement two register stages: S1 (captured request) and S2 (registered result); the team barrel shifter instance sits combinationally between them.
REQ-017 SHALL drive barrel from S1: shamt=S1.b[4:0], lr=1 for SLL, al=1 for SRA, lr=0/al=0 for SRL.
REQ-018 SHALL for illegal op 10 load S2.data=S1.a unshifted and S2.err=1; err=0 for legal ops.
REQ-019 SHALL transfer input when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-020 SHALL advance S1->S2 when S1 valid and (S2 empty or out_ready).
REQ-021 SHALL compute in_ready = !rst && (S1 empty or S1 advancing) combinationally; no dependence on in_valid.
REQ-022 SHALL give latency exactly 2 cycles: accepted at edge N, out_valid high after edge N+1 (visible cycle N+1..N+2 window), absent stalls.
REQ-023 SHALL sustain one op per cycle with out_ready held high.
REQ-024 SHALL hold out_data, out_tag, out_err stable while out_valid && !out_ready.
REQ-025 SHALL hold S1 contents stable while S1 valid and not advancing; no loss, no duplication, order preserved.
REQ-026 SHALL, on flush, clear S1 and S2 valid at next edge; a request handshaken in the flush cycle is discarded; out_valid low next cycle.
REQ-027 SHALL, when S2 drains and S1 advances in the same edge, load S2 from S1 (simultaneous pop/push).
REQ-028 SHALL ignore in_b[31:5] entirely.

Reset
REQ-029 SHALL on rst asserted clear S1/S2 valid immediately, out_valid=0, out_data=0, out_tag=0, out_err=0, in_ready=0.
REQ-030 SHALL discard all in-flight ops on reset mid-operation; first cycle after deassertion in_ready=1, out_valid=0.

Verification
REQ-031 SHALL cover: SLL a=0x00000001 b=31, out_ready=1 -> out_data=0x80000000, err=0, 2 cycles after accept.
REQ-032 SHALL cover: SRA a=0x80000000 b=0xFFFFFFE4 -> out_data=0xF8000000 (shamt 4, upper b ignored); SRL same -> 0x08000000.
REQ-033 SHALL cover: op=10 a=0x12345678 tag=7 -> out_data=0x12345678, out_err=1, out_tag=7.
REQ-034 SHALL cover: out_ready=0, 3 back-to-back requests tags 1,2,3 -> tags 1,2 accepted, in_ready=0 for tag 3; release out_ready -> outputs 1,2,3 in order, each once.
REQ-035 SHALL cover: flush with S1 and S2 full -> out_valid=0 next cycle, no stale result ever emitted; next request flows normally.
REQ-036 SHALL cover: rst pulse mid-stream between edges -> outputs zero immediately, in_ready=1 first cycle after release.
